// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: two-flop line synchroniser, mid-bit sampling FSM,
// one-cycle valid / framing-error pulses, break hold-off until the line idles.
module uart_rx_8n1 #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   // state  | meaning
   // IDLE   | line idle, waiting for a falling edge on rx_s
   // START  | timing to mid start bit to confirm it is still low
   // DATA   | sampling eight data bits at mid-bit, LSB first
   // STOP   | sampling the stop bit at mid-bit
   // BREAK  | stop bit was low; wait for the line to return high

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
      $error("uart_rx_8n1: CLKS_PER_BIT must be even and at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state, state_n;
   logic          rx_m, rx_s;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          valid_n, ferr_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx_i;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         idx         <= '0;
         shreg       <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         data_o      <= data_n;
         valid_o     <= valid_n;
         frame_err_o <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      timer_n = timer + TW'(1);
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data_o;
      valid_n = 1'b0;
      ferr_n  = 1'b0;
      case (state)
         S_IDLE: begin
            timer_n = '0;
            if (!rx_s) state_n = S_START;
         end
         S_START: begin
            if (timer == HALF_TC) begin
               timer_n = '0;
               idx_n   = '0;
               state_n = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (timer == FULL_TC) begin
               timer_n = '0;
               shreg_n = {rx_s, shreg[7:1]};
               if (idx == 3'd7) state_n = S_STOP;
               else             idx_n   = idx + 3'd1;
            end
         end
         S_STOP: begin
            if (timer == FULL_TC) begin
               timer_n = '0;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            // a held-low line must not be re-armed as a new start bit
            timer_n = '0;
            if (rx_s) state_n = S_IDLE;
         end
         default: begin
            timer_n = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: table of frames with hand-computed results, plus
// glitch, break, back-to-back and mid-frame reset sequences.
module tb_uart_rx_8n1;

   localparam int N = 16;
   localparam int LAT = 154;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       busy_o;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vq[$];
   logic [7:0] dq[$];
   int eq[$];

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   uart_rx_8n1 #(.CLKS_PER_BIT(N)) dut (
      .clk(clk),
      .rst(rst),
      .rx_i(rx_i),
      .data_o(data_o),
      .valid_o(valid_o),
      .frame_err_o(frame_err_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_o) begin
         vq.push_back(cyc);
         dq.push_back(data_o);
      end
      if (frame_err_o) eq.push_back(cyc);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int n);
      rx_i = b;
      repeat (n) @(negedge clk);
   endtask

   // drives start, data LSB first and one stop bit; returns t0
   task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
      t0 = cyc + 1;
      send_bit(1'b0, N);
      for (int i = 0; i < 8; i++) send_bit(d[i], N);
      send_bit(stop, N);
      rx_i = 1'b1;
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic clear_q();
      vq.delete();
      dq.delete();
      eq.delete();
   endtask

   initial begin
      int t0, t1, r;
      logic [7:0] prev;

      vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5};
      vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF};
      vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'hFF};
      vecs[4] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h01};
      vecs[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h80};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset data_o", {24'h0, data_o}, 32'h0);
      check("reset valid_o", {31'h0, valid_o}, 32'h0);
      check("reset frame_err_o", {31'h0, frame_err_o}, 32'h0);
      check("reset busy_o", {31'h0, busy_o}, 32'h0);
      repeat (4) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         clear_q();
         send_frame(vecs[v].data, vecs[v].stop, t0);
         repeat (20) @(negedge clk);
         check($sformatf("vec%0d data_o", v), {24'h0, data_o}, {24'h0, vecs[v].exp_data});
         check($sformatf("vec%0d valid count", v), vq.size(), {31'h0, vecs[v].exp_valid});
         check($sformatf("vec%0d err count", v), eq.size(), {31'h0, ~vecs[v].exp_valid});
         if (vq.size() == 1) check($sformatf("vec%0d valid latency", v), vq[0] - t0, LAT);
         if (eq.size() == 1) check($sformatf("vec%0d err latency", v), eq[0] - t0, LAT);
         check($sformatf("vec%0d busy idle", v), {31'h0, busy_o}, 32'h0);
      end

      // glitch: 4 low cycles must be rejected at the start-bit check
      clear_q();
      prev = data_o;
      t0 = cyc + 1;
      send_bit(1'b0, 4);
      rx_i = 1'b1;
      wait_edge(t0 + 2);
      check("glitch busy rises", {31'h0, busy_o}, 32'h1);
      wait_edge(t0 + 9);
      check("glitch busy before check", {31'h0, busy_o}, 32'h1);
      wait_edge(t0 + 10);
      check("glitch busy cleared", {31'h0, busy_o}, 32'h0);
      repeat (30) @(negedge clk);
      check("glitch no valid", vq.size(), 32'h0);
      check("glitch no err", eq.size(), 32'h0);
      check("glitch data held", {24'h0, data_o}, {24'h0, prev});

      // framing error followed by a 40-cycle break
      clear_q();
      prev = data_o;
      t0 = cyc + 1;
      send_bit(1'b0, N);
      for (int i = 0; i < 8; i++) send_bit(((8'h3C >> i) & 8'h01) != 0, N);
      send_bit(1'b0, 40);
      r = cyc + 1;
      rx_i = 1'b1;
      wait_edge(r + 1);
      check("break busy held", {31'h0, busy_o}, 32'h1);
      wait_edge(r + 2);
      check("break busy released", {31'h0, busy_o}, 32'h0);
      repeat (20) @(negedge clk);
      check("break err count", eq.size(), 32'h1);
      if (eq.size() == 1) check("break err latency", eq[0] - t0, LAT);
      check("break no valid", vq.size(), 32'h0);
      check("break data held", {24'h0, data_o}, {24'h0, prev});

      // back-to-back frames with no idle gap
      clear_q();
      send_frame(8'h00, 1'b1, t0);
      send_frame(8'hFF, 1'b1, t1);
      repeat (20) @(negedge clk);
      check("b2b valid count", vq.size(), 32'h2);
      if (vq.size() == 2) begin
         check("b2b spacing", vq[1] - vq[0], 32'd160);
         check("b2b first data", {24'h0, dq[0]}, 32'h00);
         check("b2b second data", {24'h0, dq[1]}, 32'hFF);
         check("b2b second latency", vq[1] - t1, LAT);
      end

      // reset in the middle of data bit 4 of 0x5A
      clear_q();
      rx_i = 1'b0;
      repeat (N) @(negedge clk);
      for (int i = 0; i < 4; i++) send_bit(((8'h5A >> i) & 8'h01) != 0, N);
      send_bit(1'b1, N / 2);
      rst = 1'b1;
      rx_i = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst data_o", {24'h0, data_o}, 32'h0);
      check("midrst valid_o", {31'h0, valid_o}, 32'h0);
      check("midrst frame_err_o", {31'h0, frame_err_o}, 32'h0);
      check("midrst busy_o", {31'h0, busy_o}, 32'h0);
      repeat (200) @(negedge clk);
      check("midrst no valid", vq.size(), 32'h0);
      check("midrst no err", eq.size(), 32'h0);
      send_frame(8'h81, 1'b1, t0);
      repeat (20) @(negedge clk);
      check("post-rst valid count", vq.size(), 32'h1);
      check("post-rst data", {24'h0, data_o}, 32'h81);
      if (vq.size() == 1) check("post-rst latency", vq[0] - t0, LAT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receiver for 8N1 asynchronous framing: idle-high line, one start bit, eight data bits LSB-first, one stop bit. It is the receiving end of the team's serial transmit path. It sits between an external pin and a byte-wide consumer. The incoming line is synchronised into the local clock domain, bits are sampled at mid-bit, and each frame is reported with a one-cycle valid pulse or a one-cycle framing-error pulse. There is no back-pressure: the consumer must accept a byte in the cycle it is presented.

## Interface
- CLKS_PER_BIT, 16, clock cycles per bit period; must be even and ≥ 4.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_i  in  1  asynchronous serial line, idle high.
- data_o  out  8  last correctly received byte; holds until the next good frame.
- valid_o  out  1  one-cycle pulse: data_o updated with a good frame this cycle.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- busy_o  out  1  high whenever the FSM is not IDLE.

## Operation
- Synchroniser:
  - rx_i passes through two flops, rx_m then rx_s.
  - Both flops reset to 1.
  - All FSM decisions use rx_s only.
- Counters:
  - Bit-timer: width clog2(CLKS_PER_BIT).
  - Bit-index: 3 bits.
  - Shift register: 8 bits, shifts right, new bit enters at MSB so that bit0 lands at data_o[0].
- States:
  - IDLE:
    - rx_s == 0 → START, bit-timer cleared.
  - START:
    - At bit-timer == CLKS_PER_BIT/2 − 1, sample rx_s.
    - Sample 0 → DATA; bit-timer cleared; bit-index = 0.
    - Sample 1 → IDLE (glitch rejected; no output pulse).
  - DATA:
    - At bit-timer == CLKS_PER_BIT − 1, shift in rx_s and clear the bit-timer.
    - After bit-index 7 → STOP; otherwise increment bit-index.
  - STOP:
    - At bit-timer == CLKS_PER_BIT − 1, sample rx_s.
    - Sample 1 → data_o ← shift register; valid_o = 1; → IDLE.
    - Sample 0 → frame_err_o = 1; data_o unchanged; → BREAK.
  - BREAK:
    - Wait for rx_s == 1, then → IDLE.
    - A held-low line (break) produces exactly one frame_err_o and no further frames.
- valid_o and frame_err_o are registered and mutually exclusive. Each pulses for exactly one cycle per frame.
- Reset values:
  - State IDLE; all counters 0.
  - data_o = 8'h00; valid_o = 0; frame_err_o = 0; busy_o = 0.
  - rx_m = rx_s = 1.
- Reset mid-frame: the partial frame is discarded with no pulses.
- Line held low through reset release: after 2 cycles the FSM sees rx_s = 0 and enters START. This is handled as a normal start-bit candidate.

## Timing
- Let t0 be the rising edge at which rx_m first captures the start-bit 0. Let N = CLKS_PER_BIT.
- Event edges:
  - Edge t0+1: rx_s goes low.
  - Edge t0+2: IDLE → START; busy_o high from this edge.
  - Start-bit check: edge t0+2+N/2.
  - Data bit k (k = 0..7) sampled: edge t0+2+N/2+(k+1)·N.
  - Stop bit sampled: edge t0+2+N/2+9N. valid_o or frame_err_o and busy_o = 0 are registered at this same edge; the pulse is visible for the following cycle.
- Latency with N = 16: 154 cycles from t0 to the pulse edge.
- Back-to-back frames: the FSM returns to IDLE N/2 − 1 cycles before the nominal end of the stop bit. A start bit immediately following a stop bit is therefore detected with no lost cycles.
- Tolerance: mid-bit sampling tolerates roughly ±4 % cumulative clock mismatch over a frame.

## Test plan
- Nominal byte, N = 16:
  - Stimulus: drive 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) at exactly 16 cycles/bit.
  - Required: data_o = 8'hA5 and a single valid_o pulse at edge t0+154; frame_err_o stays 0.
- Glitch rejection:
  - Stimulus: rx_i low for 4 cycles, then high.
  - Required: busy_o rises, then returns to 0 by edge t0+2+8; no valid_o or frame_err_o; data_o unchanged.
- Framing error:
  - Stimulus: send 0x3C with stop bit low, keep the line low for 40 cycles, then release high.
  - Required: exactly one frame_err_o pulse; data_o retains the previous value; busy_o stays high until 2 cycles after release; no valid_o.
- Back-to-back frames:
  - Stimulus: 0x00 then 0xFF with zero idle cycles between them.
  - Required: two valid_o pulses 160 cycles apart, with data_o = 8'h00 then 8'hFF.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle during data bit 4 of 0x5A.
  - Required: all outputs 0 in the cycle after reset; no pulse for that frame; a following 0x81 frame is received correctly.
